// File: rtl/bcd_pkg.sv
// ============================================================================
// bcd_pkg: shared state encoding and digit-correction helper for bin_to_bcd_seq
// Revision: 1.0
// ============================================================================
`default_nettype none

package bcd_pkg;

  localparam int DIGIT_W       = 4;
  localparam int BCD_MAX_DIGIT = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Pre-shift correction: a digit of 5..9 would double past 9, so bias it by 3
  function automatic logic [DIGIT_W-1:0] add3_adj(input logic [DIGIT_W-1:0] d);
    return (d > DIGIT_W'(BCD_MAX_DIGIT - 5)) ? d + DIGIT_W'(3) : d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_digit_adj.sv
// ============================================================================
// bcd_digit_adj: combinational add-3 correction of one BCD digit
// Revision: 1.0
// ============================================================================
`default_nettype none

module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] i_digit,
  output logic [DIGIT_W-1:0] o_digit
);

  assign o_digit = add3_adj(i_digit);

endmodule

`default_nettype wire

// File: rtl/bin_to_bcd_seq.sv
// ============================================================================
// bin_to_bcd_seq: one-bit-per-clock double-dabble converter, valid/ready both sides
// Revision: 1.0
// ============================================================================
`default_nettype none

module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_in_valid,
  output logic                      o_in_ready,
  input  logic [WIDTH-1:0]          i_bin,
  output logic                      o_out_valid,
  input  logic                      i_out_ready,
  output logic [DIGIT_W*DIGITS-1:0] o_bcd,
  output logic                      o_overflow
);

  localparam int c_BCD_W = DIGIT_W * DIGITS;
  localparam int c_CAT_W = c_BCD_W + WIDTH;
  localparam int c_CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t               r_state;
  logic [WIDTH-1:0]     r_sr;
  logic [c_BCD_W-1:0]   r_acc;
  logic [c_CNT_W-1:0]   r_cnt;
  logic                 r_ovf;
  logic                 r_in_ready;
  logic                 r_out_valid;

  logic [c_BCD_W-1:0]   w_adj;
  logic [c_CAT_W-1:0]   w_cat;
  logic [c_CAT_W-1:0]   w_sh;

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_digit
      bcd_digit_adj u_adj (
        .i_digit (r_acc[g*DIGIT_W +: DIGIT_W]),
        .o_digit (w_adj[g*DIGIT_W +: DIGIT_W])
      );
    end
  endgenerate

  assign w_cat = {w_adj, r_sr};
  assign w_sh  = {w_cat[c_CAT_W-2:0], 1'b0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_sr        <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_in_valid) begin
            r_sr       <= i_bin;
            r_acc      <= '0;
            r_ovf      <= 1'b0;
            r_cnt      <= c_CNT_W'(WIDTH - 1);
            r_in_ready <= 1'b0;
            r_state    <= SHIFT;
          end
        end
        SHIFT: begin
          r_acc <= w_sh[c_CAT_W-1:WIDTH];
          r_sr  <= w_sh[WIDTH-1:0];
          // A carry leaving the top digit means the value needs more digits
          if (w_cat[c_CAT_W-1]) r_ovf <= 1'b1;
          if (r_cnt == '0) begin
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_cnt <= r_cnt - c_CNT_W'(1);
          end
        end
        DONE: begin
          if (i_out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_bcd       = r_acc;
  assign o_overflow  = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_bin_to_bcd_seq.sv
// ============================================================================
// tb_bin_to_bcd_seq: randomized self-checking bench, 3-digit and 2-digit instances
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_bin_to_bcd_seq;

  localparam int c_WIDTH = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid  [2];
  logic        out_ready [2];
  logic [7:0]  bin       [2];
  logic        rdy3, rdy2, vld3, vld2, ovf3, ovf2;
  logic [11:0] bcd3;
  logic [7:0]  bcd2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  bin_to_bcd_seq #(.WIDTH(c_WIDTH), .DIGITS(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .i_in_valid(in_valid[0]), .o_in_ready(rdy3), .i_bin(bin[0]),
    .o_out_valid(vld3), .i_out_ready(out_ready[0]),
    .o_bcd(bcd3), .o_overflow(ovf3)
  );

  bin_to_bcd_seq #(.WIDTH(c_WIDTH), .DIGITS(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n),
    .i_in_valid(in_valid[1]), .o_in_ready(rdy2), .i_bin(bin[1]),
    .o_out_valid(vld2), .i_out_ready(out_ready[1]),
    .o_bcd(bcd2), .o_overflow(ovf2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: decimal digits by plain division, truncated to the digit count
  function automatic logic [31:0] ref_bcd(input int v, input int d);
    logic [31:0] r = 0;
    int x = v;
    for (int i = 0; i < d; i++) begin
      r = r | (32'(x % 10) << (4 * i));
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic ref_ovf(input int v, input int d);
    return v > (10 ** d) - 1;
  endfunction

  function automatic logic [31:0] obs_bcd(input int sel);
    return (sel != 0) ? {24'd0, bcd2} : {20'd0, bcd3};
  endfunction
  function automatic logic obs_rdy(input int sel);
    return (sel != 0) ? rdy2 : rdy3;
  endfunction
  function automatic logic obs_vld(input int sel);
    return (sel != 0) ? vld2 : vld3;
  endfunction
  function automatic logic obs_ovf(input int sel);
    return (sel != 0) ? ovf2 : ovf3;
  endfunction

  task automatic convert(input int sel, input int v, input bit hold, input int bp);
    int          k;
    bit          seen;
    int          d;
    logic [31:0] exp_b;
    d = (sel != 0) ? 2 : 3;
    exp_b = ref_bcd(v, d);
    @(negedge clk);
    check("in_ready_idle", 32'(obs_rdy(sel)), 32'd1);
    in_valid[sel] = 1'b1;
    bin[sel] = 8'(v);
    @(posedge clk);
    #1;
    if (!hold) in_valid[sel] = 1'b0;
    bin[sel] = 8'($urandom);
    seen = 0;
    k = 0;
    while (!seen && k < c_WIDTH + 4) begin
      @(posedge clk);
      #1;
      k++;
      if (obs_vld(sel)) seen = 1;
      else check("in_ready_busy", 32'(obs_rdy(sel)), 32'd0);
    end
    in_valid[sel] = 1'b0;
    check("latency", 32'(k), 32'(c_WIDTH));
    check("bcd", obs_bcd(sel), exp_b);
    check("overflow", 32'(obs_ovf(sel)), 32'(ref_ovf(v, d)));
    repeat (bp) begin
      @(posedge clk);
      #1;
      check("bp_valid", 32'(obs_vld(sel)), 32'd1);
      check("bp_bcd", obs_bcd(sel), exp_b);
    end
    out_ready[sel] = 1'b1;
    @(posedge clk);
    #1;
    out_ready[sel] = 1'b0;
    check("valid_drop", 32'(obs_vld(sel)), 32'd0);
    check("in_ready_back", 32'(obs_rdy(sel)), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      in_valid[i]  = 1'b0;
      out_ready[i] = 1'b0;
      bin[i]       = 8'd0;
    end
    #12;
    check("rst_in_ready", 32'(rdy3), 32'd1);
    check("rst_out_valid", 32'(vld3), 32'd0);
    check("rst_bcd", {20'd0, bcd3}, 32'd0);
    check("rst_overflow", 32'(ovf3), 32'd0);
    check("rst_out_valid2", 32'(vld2), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    convert(0, 0, 0, 0);
    convert(0, 10, 0, 0);
    convert(0, 99, 0, 0);
    convert(0, 255, 0, 0);
    convert(1, 100, 0, 0);
    convert(1, 99, 0, 0);
    convert(0, 137, 0, 5);

    // Asynchronous abort partway through a conversion
    @(negedge clk);
    in_valid[0] = 1'b1;
    bin[0] = 8'd200;
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_in_ready", 32'(rdy3), 32'd1);
    check("abort_out_valid", 32'(vld3), 32'd0);
    check("abort_bcd", {20'd0, bcd3}, 32'd0);
    check("abort_overflow", 32'(ovf3), 32'd0);
    rst_n = 1'b1;
    convert(0, 42, 0, 0);

    for (int v = 0; v < 256; v++)
      convert(0, v, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
    for (int i = 0; i < 40; i++)
      convert(1, int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
Sequential binary-to-BCD converter using iterative shift-and-add-3 (double dabble), one bit per clock. It is the reverse-direction partner of the arithmetic group's BCD-to-binary path. It uses a valid/ready handshake on both sides and flags values that do not fit in DIGITS decimal digits.

Parameters:
WIDTH, 8, bit width of the binary input (>=1)
DIGITS, 3, number of BCD output digits (>=1)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  binary operand valid
in_ready  output  1  converter idle and able to accept an operand
bin  input  WIDTH  binary operand, sampled on the accept edge
out_valid  output  1  result valid
out_ready  input  1  consumer accepts the result
bcd  output  4*DIGITS  packed BCD result; digit 0 (units) in bits [3:0]
overflow  output  1  operand exceeds 10^DIGITS-1; bcd is then the value mod 10^DIGITS

Behaviour:
- Reset is asynchronous and active-low. While rst_n=0, the block is in state IDLE with in_ready=1, out_valid=0, bcd=0, overflow=0, and the internal shift register and counter at 0.
- States are IDLE, SHIFT and DONE.
- IDLE:
  - in_ready=1.
  - When in_valid=1 on a rising edge, latch bin into the shift register, clear the BCD accumulator and the overflow sticky bit, load bit counter=WIDTH-1, and go to SHIFT.
- SHIFT:
  - in_ready=0 and out_valid=0.
  - Each cycle, first adjust every accumulator digit: digit>=5 becomes digit+3, in 4 bits. Then shift {accumulator, shift register} left by 1.
  - Any bit shifted out of the MSB of the top digit sets the overflow sticky bit.
  - When counter=0 on this edge, go to DONE; otherwise decrement the counter.
  - Exactly WIDTH shift edges occur.
- DONE:
  - out_valid=1. bcd and overflow are driven from registers and stay stable while out_ready=0.
  - When out_valid and out_ready are both 1 on a rising edge, go to IDLE and deassert out_valid.
  - in_ready returns to 1 in the following cycle; there is no same-cycle re-accept.
- Latency: the accept edge is E0. out_valid is 1 after edge E0+WIDTH, which is WIDTH+1 edges including the accept edge. Throughput is one conversion per WIDTH+2 cycles with out_ready held at 1.
- Every digit in bcd is always in the range 0..9, including the overflow case.
- When DIGITS*4 >= WIDTH + ceil(WIDTH/3), overflow can never assert. The logic is still synthesized.
- in_valid is ignored outside IDLE. bin may change freely after the accept edge.
- out_ready is ignored outside DONE.
- rst_n falling mid-conversion or in DONE aborts immediately to IDLE with reset values. The partial result is discarded.
- bin=0 produces bcd=0 after the full WIDTH cycles; there is no early exit.

Decomposition:
- Shared package bcd_pkg:
  - state enum {IDLE, SHIFT, DONE}
  - localparam DIGIT_W=4
  - function add3_adj(4-bit) returning the corrected digit
  - localparam BCD_MAX_DIGIT=9
- One natural sub-module: bcd_digit_adj. It is combinational, takes a 4-bit input and returns a 4-bit output (input>=5 gives input+3). It is instantiated DIGITS times in a generate loop. The top level holds the FSM, counter, shift register and handshake.

Test Plan:
- Defaults; reset, then bin=8'd0 with in_valid pulsed -> after 8 shift edges out_valid=1, bcd=12'h000, overflow=0; in_ready=0 throughout the conversion.
- Sweep bin=8'd10, 8'd99 and 8'd255 with out_ready=1 -> bcd=12'h010, 12'h099 and 12'h255; overflow=0 each time; out_valid exactly WIDTH edges after each accept.
- DIGITS=2, bin=8'd100 -> bcd=8'h00, overflow=1. Then bin=8'd99 -> bcd=8'h99, overflow=0, confirming the sticky bit is cleared per operand.
- Backpressure: bin=8'd137, out_ready=0 for 5 cycles after out_valid -> bcd stays 12'h137 and out_valid stays 1. Assert out_ready -> out_valid drops next edge; in_ready=1 one cycle later.
- Pulse rst_n low for 1 ns, asynchronously, at shift edge 4 of bin=8'd200 -> outputs zero immediately, state IDLE. A fresh bin=8'd42 then gives bcd=12'h042.
- Exhaustive self-check of 0..255 against a reference model computing value/100, (value/10)%10 and value%10; also hold in_valid=1 during SHIFT to confirm no extra accept.
